// File: rtl/eje6_seq.sv
// rtl/eje6_seq.sv - serial stimulus sequencer and result collector for a two-input sequential AND datapath
//
// Purpose:
//   Latches two WIDTH-bit patterns on an accepted start, clears the datapath,
//   shifts the patterns LSB-first onto dp_a/dp_b one bit per clock, and
//   collects the datapath's dp_and1 response LAT cycles later into a parallel
//   result word plus a population count.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   job request, accepted only in IDLE
//   pat_a     in   WIDTH-bit pattern serialized onto dp_a
//   pat_b     in   WIDTH-bit pattern serialized onto dp_b
//   dp_and1   in   datapath response
//   dp_reset  out  one-cycle datapath clear (LOAD)
//   dp_a      out  serial bit to datapath A
//   dp_b      out  serial bit to datapath B
//   busy      out  high in LOAD, SHIFT and DRAIN
//   done      out  one-cycle completion pulse
//   result    out  captured response, bit n belongs to pattern bit n
//   ones      out  number of 1s in result

module eje6_seq #(
    parameter int WIDTH = 9,
    parameter int LAT   = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pat_a,
    input  logic [WIDTH-1:0] pat_b,
    input  logic             dp_and1,
    output logic             dp_reset,
    output logic             dp_a,
    output logic             dp_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] ones
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat_a;
    logic [WIDTH-1:0] r_pat_b;
    logic [IW-1:0]    r_idx;
    logic [1:0]       r_drain;

    // Capture tag delay line. Stage 0 describes the bit currently on dp_a/dp_b;
    // stage LAT describes the bit whose response is on dp_and1 right now.
    logic             r_tag_vld [0:LAT];
    logic [IW-1:0]    r_tag_idx [0:LAT];

    logic [IW-1:0]    w_next_idx;
    logic             w_cap_vld;
    logic [IW-1:0]    w_cap_idx;

    assign w_next_idx = r_idx + IW'(1);
    assign w_cap_vld  = r_tag_vld[LAT];
    assign w_cap_idx  = r_tag_idx[LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pat_a  <= '0;
            r_pat_b  <= '0;
            r_idx    <= '0;
            r_drain  <= '0;
            dp_reset <= 1'b0;
            dp_a     <= 1'b0;
            dp_b     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ones     <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_idx[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
            r_tag_vld[0] <= 1'b0;
            r_tag_idx[0] <= '0;

            // Capture runs independently of the FSM so it naturally spans
            // the tail of SHIFT and all of DRAIN.
            if (w_cap_vld) begin
                result[w_cap_idx] <= dp_and1;
                if (dp_and1) begin
                    ones <= ones + CNT_W'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    dp_reset <= 1'b0;
                    dp_a     <= 1'b0;
                    dp_b     <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        r_pat_a  <= pat_a;
                        r_pat_b  <= pat_b;
                        r_idx    <= '0;
                        result   <= '0;
                        ones     <= '0;
                        dp_reset <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    dp_reset     <= 1'b0;
                    r_idx        <= '0;
                    dp_a         <= r_pat_a[0];
                    dp_b         <= r_pat_b[0];
                    r_tag_vld[0] <= 1'b1;
                    r_tag_idx[0] <= '0;
                    r_state      <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (r_idx == IW'(WIDTH - 1)) begin
                        dp_a <= 1'b0;
                        dp_b <= 1'b0;
                        if (LAT > 0) begin
                            r_drain <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_idx        <= w_next_idx;
                        dp_a         <= r_pat_a[w_next_idx];
                        dp_b         <= r_pat_b[w_next_idx];
                        r_tag_vld[0] <= 1'b1;
                        r_tag_idx[0] <= w_next_idx;
                    end
                end

                S_DRAIN: begin
                    dp_a <= 1'b0;
                    dp_b <= 1'b0;
                    if (r_drain == 2'(LAT - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end

                S_DONE: begin
                    // start is deliberately ignored here; no queuing.
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eje6_seq.sv
// tb/tb_eje6_seq.sv - scoreboard testbench for eje6_seq with a cycle-level reference model

module tb_eje6_seq;

    localparam int W     = 9;
    localparam int L     = 1;
    localparam int NCYC  = 4096;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] pat_a = '0;
    logic [W-1:0] pat_b = '0;
    logic         dp_and1;
    logic         dp_reset, dp_a, dp_b, busy, done;
    logic [W-1:0] result;
    logic [3:0]   ones;

    logic         start0 = 1'b0;
    logic         dp_and1_0;
    logic         dp_reset0, dp_a0, dp_b0, busy0, done0;
    logic [W-1:0] result0;
    logic [3:0]   ones0;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    int last_done_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath models: registered AND (LAT=1) and combinational AND (LAT=0).
    always @(posedge clk) begin
        if (dp_reset) dp_and1 <= 1'b0;
        else          dp_and1 <= dp_a & dp_b;
    end
    initial dp_and1 = 1'b0;
    assign dp_and1_0 = dp_a0 & dp_b0;

    eje6_seq #(.WIDTH(W), .LAT(L), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pat_a(pat_a), .pat_b(pat_b),
        .dp_and1(dp_and1), .dp_reset(dp_reset), .dp_a(dp_a), .dp_b(dp_b),
        .busy(busy), .done(done), .result(result), .ones(ones)
    );

    eje6_seq #(.WIDTH(W), .LAT(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .pat_a(pat_a), .pat_b(pat_b),
        .dp_and1(dp_and1_0), .dp_reset(dp_reset0), .dp_a(dp_a0), .dp_b(dp_b0),
        .busy(busy0), .done(done0), .result(result0), .ones(ones0)
    );

    // Reference model: per-cycle expected outputs plus a job scoreboard.
    typedef struct {
        int           dcyc;
        logic [W-1:0] res;
        int           n1;
    } job_t;
    job_t sb[$];

    bit exp_a    [0:NCYC-1];
    bit exp_b    [0:NCYC-1];
    bit exp_rst  [0:NCYC-1];
    bit exp_busy [0:NCYC-1];
    bit exp_done [0:NCYC-1];
    bit exp_zero [0:NCYC-1];
    int next_free = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void put(input int i, input bit v, inout bit arr [0:NCYC-1]);
        if (i >= 0 && i < NCYC) arr[i] = v;
    endfunction

    // One clock of stimulus; updates the model for the cycle being driven.
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic r);
        int c;
        job_t j;
        @(posedge clk);
        #2;
        start = s; pat_a = a; pat_b = b; reset = r;
        c = cyc;
        if (r) begin
            for (int k = c + 1; k < c + 20 && k < NCYC; k++) begin
                exp_a[k] = 0; exp_b[k] = 0; exp_rst[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
            end
            put(c + 1, 1'b1, exp_zero);
            if (sb.size() > 0 && sb[$].dcyc > c) void'(sb.pop_back());
            next_free = c + 1;
        end else if (s && c >= next_free) begin
            put(c + 1, 1'b1, exp_rst);
            for (int k = c + 1; k <= c + 1 + W + L; k++) put(k, 1'b1, exp_busy);
            for (int n = 0; n < W; n++) begin
                put(c + 2 + n, a[n], exp_a);
                put(c + 2 + n, b[n], exp_b);
            end
            put(c + 2 + W + L, 1'b1, exp_done);
            j.dcyc = c + 2 + W + L;
            j.res  = a & b;
            j.n1   = $countones(a & b);
            sb.push_back(j);
            next_free = c + W + L + 3;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, pat_a, pat_b, 1'b0);
    endtask

    // Monitor: compares every observable output against the model each cycle.
    always @(negedge clk) begin
        if (mon_en && cyc < NCYC) begin
            chk("dp_a", dp_a, exp_a[cyc]);
            chk("dp_b", dp_b, exp_b[cyc]);
            chk("dp_reset", dp_reset, exp_rst[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("done", done, exp_done[cyc]);
            if (exp_zero[cyc]) begin
                chk("result_after_reset", result, 0);
                chk("ones_after_reset", ones, 0);
            end
            if (done) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got done=1 expected no pending job (cycle %0d)", cyc);
                end else begin
                    job_t j;
                    j = sb.pop_front();
                    chk("done_cycle", cyc, j.dcyc);
                    chk("result", result, j.res);
                    chk("ones", ones, j.n1);
                end
            end
        end
    end

    initial begin
        int c0;
        int d0;
        drive(1'b0, '0, '0, 1'b1);
        mon_en = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0);

        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dp_reset", dp_reset, 0);
        chk("reset_dp_a", dp_a, 0);
        chk("reset_result", result, 0);
        chk("reset_ones", ones, 0);

        // Default patterns
        drive(1'b1, 9'b011101110, 9'b001000100, 1'b0);
        c0 = cyc;
        drive(1'b0, 9'h1AB, 9'h0F3, 1'b0);
        idle(14);
        chk("default_latency", last_done_cyc - c0, 12);
        chk("default_result", result, 9'b001000100);
        chk("default_ones", ones, 2);

        // All ones
        drive(1'b1, 9'h1FF, 9'h1FF, 1'b0);
        idle(14);
        chk("allones_result", result, 9'h1FF);
        chk("allones_ones", ones, 9);

        // Disjoint
        drive(1'b1, 9'h155, 9'h0AA, 1'b0);
        c0 = cyc;
        idle(14);
        chk("disjoint_latency", last_done_cyc - c0, 12);
        chk("disjoint_result", result, 0);
        chk("disjoint_ones", ones, 0);

        // Start held high with patterns changing every cycle
        for (int i = 0; i < 45; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b0);
        idle(15);

        // Reset during SHIFT bit 4
        drive(1'b1, 9'h1FF, 9'h1FF, 1'b0);
        idle(5);
        drive(1'b0, 9'h1FF, 9'h1FF, 1'b1);
        drive(1'b0, 9'h1FF, 9'h1FF, 1'b0);
        chk("abort_busy", busy, 0);
        chk("abort_dp_a", dp_a, 0);
        chk("abort_dp_b", dp_b, 0);
        chk("abort_result", result, 0);
        chk("abort_ones", ones, 0);
        idle(14);
        drive(1'b1, 9'h0F0, 9'h1F8, 1'b0);
        idle(14);
        chk("after_abort_result", result, 9'h0F0);
        chk("after_abort_ones", ones, 4);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(3) == 0), W'($urandom), W'($urandom),
                  ($urandom_range(99) == 0));
        end
        idle(16);
        chk("scoreboard_empty", sb.size(), 0);

        // LAT=0 build with combinational AND
        @(posedge clk);
        #2;
        start0 = 1'b1; pat_a = 9'b011101110; pat_b = 9'b001000100;
        c0 = cyc;
        @(posedge clk);
        #2;
        start0 = 1'b0; pat_a = 9'h1FF; pat_b = 9'h1FF;
        d0 = -1;
        for (int i = 0; i < 20 && d0 < 0; i++) begin
            if (done0) d0 = cyc;
            else begin
                @(posedge clk);
                #2;
            end
        end
        chk("lat0_latency", (d0 < 0) ? 32'hFFFF_FFFF : 32'(d0 - c0), 11);
        chk("lat0_result", result0, 9'b001000100);
        chk("lat0_ones", ones0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
